sqrt_stream_buf: RTL and testbench

SQRT_STREAM_BUF -- requirements
Module: sqrt_stream_buf

---
 rtl/sqrt_pkg.sv | 13 +
 rtl/sync_fifo_mem.sv | 37 +++
 rtl/sqrt_stream_buf.sv | 153 +++++++++++++++
 tb/tb_sqrt_stream_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared constants and FSM state type for the sqrt result buffer
// Holds the sqrt pipeline latency, the default buffer depth and the buffer control states.
package sqrt_pkg;

    localparam int SQRT16_LATENCY     = 16;
    localparam int SQRT_BUF_DEPTH_DEF = 32;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x DATA_W storage, one write port, one registered read port
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe; wr_data stored at wr_addr
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data loads the word at rd_addr
//   rd_addr  read address
//   rd_data  registered read data, held while rd_en is low
module sync_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Write-through on an address collision so a word written into an
        // empty buffer reaches the read register in the same cycle.
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/sqrt_stream_buf.sv
// rtl/sqrt_stream_buf.sv - credit-controlled FWFT result buffer behind a sqrt pipeline
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   issue_vld_i  upstream wants to launch an operand
//   issue_rdy_o  credit available and flush done; launch = issue_vld_i & issue_rdy_o
//   res_data_i   result word from the sqrt pipeline
//   res_vld_i    result word valid
//   m_data_o     head result to the consumer (0 when empty)
//   m_vld_o      m_data_o valid
//   m_rdy_i      consumer ready; pop = m_vld_o & m_rdy_i
//   level_o      stored entries, including the head
//   ovf_err_o    sticky: a result arrived while the buffer was full
module sqrt_stream_buf
    import sqrt_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = SQRT_BUF_DEPTH_DEF,
    parameter int FLUSH_CYC = SQRT16_LATENCY,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_vld_i,
    output logic              issue_rdy_o,
    input  logic [DATA_W-1:0] res_data_i,
    input  logic              res_vld_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_vld_o,
    input  logic              m_rdy_i,
    output logic [LVL_W-1:0]  level_o,
    output logic              ovf_err_o
);

    buf_state_t        state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [LVL_W-1:0]  credit_q, level_q, level_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              vld_q, ovf_q;

    logic              launch, pop, full, wr_req, wr_en, ovf_set;
    logic              rd_en;
    logic [PTR_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FLUSH;
            flush_cnt_q <= CNT_W'(FLUSH_CYC - 1);
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- handshakes ----------------
    assign issue_rdy_o = (state_q == RUN) && (credit_q != '0);
    assign launch      = issue_vld_i && issue_rdy_o;
    assign pop         = vld_q && m_rdy_i;
    assign full        = (level_q == LVL_W'(DEPTH));

    // Pipeline output is stale until the flush window has passed.
    assign wr_req  = (state_q == RUN) && res_vld_i;
    assign wr_en   = wr_req && (!full || pop);
    assign ovf_set = wr_req && full && !pop;

    // ---------------- credit ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= LVL_W'(DEPTH);
        end else begin
            case ({launch, pop})
                2'b10:   credit_q <= credit_q - LVL_W'(1);
                // Saturate: words injected without a launch must not push
                // the credit beyond the buffer size.
                2'b01:   if (credit_q != LVL_W'(DEPTH)) credit_q <= credit_q + LVL_W'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // ---------------- level / pointers ----------------
    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            vld_q   <= (level_d != '0);
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    // The read register always holds the head entry. On a pop it fetches the
    // next entry; when empty, a write lands there through the write-through path.
    assign rd_en   = pop || (wr_en && (level_q == '0));
    assign rd_addr = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (res_data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Read register is not reset; mask it so an empty buffer shows zero.
    assign m_data_o  = vld_q ? rd_data : '0;
    assign m_vld_o   = vld_q;
    assign level_o   = level_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_sqrt_stream_buf.sv
// tb/tb_sqrt_stream_buf.sv - self-checking bench for sqrt_stream_buf with a 16-cycle sqrt pipeline model
module tb_sqrt_stream_buf;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int LAT    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_vld = 1'b0;
    logic              issue_rdy;
    logic [DATA_W-1:0] res_data;
    logic              res_vld;
    logic [DATA_W-1:0] m_data;
    logic              m_vld;
    logic              m_rdy = 1'b0;
    logic [5:0]        level;
    logic              ovf;

    logic [15:0]       op = '0;
    logic              force_en = 1'b0, force_vld = 1'b0, force_expect = 1'b0;
    logic [15:0]       force_data = '0;

    logic              pipe_vld [LAT];
    logic [15:0]       pipe_dat [LAT];
    logic              launch_s = 1'b0;
    logic              mon_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int lvl_max = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    always #5 clk = ~clk;

    assign res_vld  = force_en ? force_vld  : pipe_vld[LAT-1];
    assign res_data = force_en ? force_data : pipe_dat[LAT-1];

    sqrt_stream_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FLUSH_CYC(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_vld_i (issue_vld),
        .issue_rdy_o (issue_rdy),
        .res_data_i  (res_data),
        .res_vld_i   (res_vld),
        .m_data_o    (m_data),
        .m_vld_o     (m_vld),
        .m_rdy_i     (m_rdy),
        .level_o     (level),
        .ovf_err_o   (ovf)
    );

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, v}) r = t;
        end
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: launches feed the expected queue, pops are checked in order.
    always @(negedge clk) begin
        launch_s = issue_vld && issue_rdy;
        if (mon_en) begin
            if (launch_s) exp_q.push_back(isqrt({op, 16'h0}));
            if (force_en && force_vld && force_expect) exp_q.push_back(force_data);
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (m_vld && m_rdy) begin
                got_q.push_back(m_data);
                if (exp_q.size() == 0) chk("unexpected_pop", {16'h0, m_data}, 32'hFFFF_FFFF);
                else chk("pop_order", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // sqrt pipeline model: no reset, fixed latency.
    initial for (int i = 0; i < LAT; i++) begin pipe_vld[i] = 1'b0; pipe_dat[i] = '0; end
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
        end
        pipe_vld[0] <= launch_s;
        pipe_dat[0] <= isqrt({op, 16'h0});
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue_vld = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic wait_run();
        for (int c = 0; c < 20 && !issue_rdy; c++) step();
        chk("wait_run", {31'd0, issue_rdy}, 32'd1);
    endtask

    task automatic wait_level(input int n, input int lim);
        for (int c = 0; c < lim && int'(level) != n; c++) step();
        chk("wait_level", {26'd0, level}, n);
    endtask

    task automatic wait_empty(input int lim);
        for (int c = 0; c < lim && exp_q.size() != 0; c++) step();
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic fill_full(input logic [15:0] base);
        m_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            op = base + 16'(i); issue_vld = 1'b1; step();
        end
        issue_vld = 1'b0;
        wait_level(DEPTH, 40);
        chk("fill_rdy_low", {31'd0, issue_rdy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] exp;
    } vec_t;
    vec_t tab [10];

    initial begin
        int drops;
        int n_launch;
        int bad_lvl;

        tab[0] = '{16'd0,     16'd0};
        tab[1] = '{16'd1,     16'd256};
        tab[2] = '{16'd2,     16'd362};
        tab[3] = '{16'd3,     16'd443};
        tab[4] = '{16'd4,     16'd512};
        tab[5] = '{16'd9,     16'd768};
        tab[6] = '{16'd10,    16'd809};
        tab[7] = '{16'd100,   16'd2560};
        tab[8] = '{16'd16384, 16'd32768};
        tab[9] = '{16'd65535, 16'd65535};

        // ---- reset state and flush window ----
        do_reset();
        mon_en = 1'b1;
        chk("rst_level", {26'd0, level}, 0);
        chk("rst_m_vld", {31'd0, m_vld}, 0);
        chk("rst_m_data", {16'd0, m_data}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_credit", {26'd0, dut.credit_q}, DEPTH);
        for (int k = 1; k <= 17; k++) begin
            force_en = (k == 5); force_vld = (k == 5); force_data = 16'h1234;
            @(negedge clk);
            chk($sformatf("flush_rdy_c%0d", k), {31'd0, issue_rdy}, (k == 17) ? 32'd1 : 32'd0);
            step();
        end
        force_en = 1'b0; force_vld = 1'b0;
        chk("flush_no_write", {26'd0, level}, 0);
        chk("flush_no_ovf", {31'd0, ovf}, 0);

        // ---- table vectors through the pipeline ----
        m_rdy = 1'b1; got_q.delete();
        for (int i = 0; i < 10; i++) begin
            op = tab[i].op; issue_vld = 1'b1; step();
        end
        issue_vld = 1'b0;
        for (int c = 0; c < 60 && got_q.size() < 10; c++) step();
        chk("tab_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            chk($sformatf("tab_%0d", i), {16'd0, got_q[i]}, {16'd0, tab[i].exp});

        // ---- streaming 100 operands ----
        got_q.delete(); lvl_max = 0; drops = 0;
        for (int i = 0; i < 100; i++) begin
            op = 16'($urandom); issue_vld = 1'b1;
            @(negedge clk);
            if (!issue_rdy) drops++;
            step();
        end
        issue_vld = 1'b0;
        for (int c = 0; c < 200 && got_q.size() < 100; c++) step();
        chk("stream_count", got_q.size(), 100);
        chk("stream_rdy_drops", drops, 0);
        chk("stream_lvl_le17", {31'd0, lvl_max <= 17}, 1);

        // ---- backpressure ----
        got_q.delete(); m_rdy = 1'b0; n_launch = 0;
        for (int i = 0; i < 60; i++) begin
            op = 16'h0100 + 16'(i); issue_vld = 1'b1;
            @(negedge clk);
            if (issue_vld && issue_rdy) n_launch++;
            step();
        end
        issue_vld = 1'b0;
        chk("bp_launches", n_launch, DEPTH);
        chk("bp_rdy_low", {31'd0, issue_rdy}, 0);
        wait_level(DEPTH, 40);
        chk("bp_ovf", {31'd0, ovf}, 0);
        m_rdy = 1'b1;
        @(negedge clk);
        chk("bp_first_pop_rdy", {31'd0, issue_rdy}, 0);
        step();
        @(negedge clk);
        chk("bp_rdy_after_pop", {31'd0, issue_rdy}, 1);
        for (int c = 0; c < 60 && got_q.size() < DEPTH; c++) step();
        chk("bp_pops", got_q.size(), DEPTH);

        // ---- forced overflow ----
        fill_full(16'h0200);
        force_en = 1'b1; force_vld = 1'b1; force_data = 16'hBEEF; force_expect = 1'b0;
        step();
        force_en = 1'b0; force_vld = 1'b0;
        @(negedge clk);
        chk("ovf_set", {31'd0, ovf}, 1);
        chk("ovf_level", {26'd0, level}, DEPTH);
        step(); step(); step();
        chk("ovf_sticky", {31'd0, ovf}, 1);
        m_rdy = 1'b1;
        wait_empty(60);
        chk("ovf_sticky_drain", {31'd0, ovf}, 1);
        m_rdy = 1'b0;

        // ---- reset mid-stream ----
        do_reset();
        chk("rst_clears_ovf", {31'd0, ovf}, 0);
        wait_run();
        for (int i = 0; i < 18; i++) begin
            op = 16'h0400 + 16'(i); issue_vld = 1'b1; step();
        end
        issue_vld = 1'b0;
        wait_level(10, 40);
        rst = 1'b1; step(); rst = 1'b0;
        exp_q.delete(); got_q.delete();
        chk("mid_level", {26'd0, level}, 0);
        chk("mid_m_vld", {31'd0, m_vld}, 0);
        chk("mid_m_data", {16'd0, m_data}, 0);
        chk("mid_credit", {26'd0, dut.credit_q}, DEPTH);
        chk("mid_rdy", {31'd0, issue_rdy}, 0);
        m_rdy = 1'b1;
        for (int c = 0; c < 30; c++) step();
        chk("mid_no_stale", got_q.size(), 0);

        // ---- full with simultaneous write and pop, 3 laps ----
        fill_full(16'h0300);
        m_rdy = 1'b1; force_en = 1'b1; force_vld = 1'b1; force_expect = 1'b1;
        bad_lvl = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            force_data = 16'hA000 + 16'(i);
            @(negedge clk);
            if (int'(level) != DEPTH) bad_lvl++;
            step();
        end
        force_en = 1'b0; force_vld = 1'b0; force_expect = 1'b0;
        chk("full_wr_pop_level", bad_lvl, 0);
        chk("full_wr_pop_ovf", {31'd0, ovf}, 0);
        wait_empty(80);
        chk("final_level", {26'd0, level}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
